// File: rtl/mps_seq_pkg.sv
// mps_seq_pkg: shared state encodings and fail codes for the MPS
// operation sequencer (mps_seq_fsm and mps_hold_timer).
package mps_seq_pkg;

    // ON sequence states
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLR       = 3'd1;
    localparam logic [2:0] ST_STEP_CHK  = 3'd2;
    localparam logic [2:0] ST_STEP_DONE = 3'd3;
    localparam logic [2:0] ST_SYSTEM_ON = 3'd4;
    localparam logic [2:0] ST_FAIL      = 3'd5;

    // OFF sequence states
    localparam logic [1:0] OFF_IDLE     = 2'd0;
    localparam logic [1:0] OFF_MAIN_OFF = 2'd1;
    localparam logic [1:0] OFF_DISCHA   = 2'd2;
    localparam logic [1:0] OFF_DONE     = 2'd3;

    // Fail codes reported on o_fail_code
    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_INTL    = 2'd1;
    localparam logic [1:0] FC_TIMEOUT = 2'd2;
    localparam logic [1:0] FC_ABORT   = 2'd3;

endpackage

// File: rtl/mps_hold_timer.sv
// mps_hold_timer: saturating hold counter followed by a saturating
// timeout counter. The hold counter runs while enabled until it reaches
// i_hold_lim (o_done). After that, and only when i_to_en is set, the
// timeout counter runs; o_timeout rises once it reaches i_to_lim.
// i_clr has priority over i_en and zeroes both counters.
module mps_hold_timer #(
    parameter int CNT_W = 29
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_to_en,
    input  logic [CNT_W-1:0] i_hold_lim,
    input  logic [CNT_W-1:0] i_to_lim,
    output logic             o_done,
    output logic             o_timeout
);

    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] r_to_cnt;
    logic             w_done;

    // >= rather than == so that lowering the limit mid-count still ends the hold
    assign w_done    = (r_hold_cnt >= i_hold_lim);
    assign o_done    = w_done;
    assign o_timeout = i_to_en && w_done && (r_to_cnt >= i_to_lim);

    // Hold counter first, then timeout counter; both saturate, never wrap
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (i_clr) begin
            r_hold_cnt <= '0;
            r_to_cnt   <= '0;
        end else if (i_en) begin
            if (!w_done) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end else if (i_to_en && (r_to_cnt != {CNT_W{1'b1}})) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mps_seq_fsm.sv
// mps_seq_fsm: MPS ON/OFF operation sequencer.
// ON: CLR, then NUM_STEPS check steps (DI level or DC-link voltage), each
// with a hold time and a timeout, then SYSTEM_ON. OFF: main-off hold,
// discharge below threshold, OFF_DONE. Interlock and OFF-request abort
// are reported through o_fail_code / o_fail_step.
// Optional build macro MPS_SEQ_FAIL_LATCH_EN: FAIL is held until
// i_fail_clr instead of lasting a single cycle.
module mps_seq_fsm
    import mps_seq_pkg::*;
#(
    parameter int NUM_STEPS = 6,
    parameter int DI_W      = 16,
    parameter int DCV_W     = 24,
    parameter int CNT_W     = 29,
    parameter int SEL_W     = $clog2(DI_W)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_on_req,
    input  logic                       i_off_req,
    input  logic                       i_intl,
    input  logic [DI_W-1:0]            i_ext_di,
    input  logic [DCV_W-1:0]           i_dc_v,
    input  logic [DCV_W-1:0]           i_dc_on_th,
    input  logic [DCV_W-1:0]           i_dc_off_th,
    input  logic [NUM_STEPS*SEL_W-1:0] i_step_sel,
    input  logic [NUM_STEPS-1:0]       i_step_pol,
    input  logic [NUM_STEPS-1:0]       i_step_is_dc,
    input  logic [CNT_W-1:0]           i_hold_cyc,
    input  logic [CNT_W-1:0]           i_timeout_cyc,
    input  logic [CNT_W-1:0]           i_off_hold_cyc,
    input  logic                       i_fail_clr,
    output logic [2:0]                 o_on_state,
    output logic [1:0]                 o_off_state,
    output logic [3:0]                 o_step_idx,
    output logic [3:0]                 o_fail_step,
    output logic [1:0]                 o_fail_code,
    output logic                       o_system_on,
    output logic                       o_busy
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_STEPS - 1);

    logic [2:0]       r_on_state;
    logic [1:0]       r_off_state;
    logic [3:0]       r_step_idx;
    logic [3:0]       r_fail_step;
    logic [1:0]       r_fail_code;
    logic             r_cond;

    logic [2:0]       w_on_nxt;
    logic [1:0]       w_off_nxt;
    logic [1:0]       w_fail_code_nxt;
    logic             w_fail_set;
    logic             w_clr_entry;
    logic [3:0]       w_step_idx_nxt;
    logic [SEL_W-1:0] w_cond_sel;
    logic             w_cond_pol;
    logic             w_cond_dc;
    logic             w_cond_nxt;
    logic             w_st_clr;
    logic             w_st_en;
    logic             w_st_done;
    logic             w_st_to;
    logic             w_off_en;
    logic             w_off_done;
    logic             w_unused_off_to;

`ifndef MPS_SEQ_FAIL_LATCH_EN
    logic w_unused_fail_clr;
    assign w_unused_fail_clr = i_fail_clr;
`endif

    mps_hold_timer #(.CNT_W(CNT_W)) u_step_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_st_clr),
        .i_en       (w_st_en),
        .i_to_en    (1'b1),
        .i_hold_lim (i_hold_cyc),
        .i_to_lim   (i_timeout_cyc),
        .o_done     (w_st_done),
        .o_timeout  (w_st_to)
    );

    mps_hold_timer #(.CNT_W(CNT_W)) u_off_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (~w_off_en),
        .i_en       (w_off_en),
        .i_to_en    (1'b0),
        .i_hold_lim (i_off_hold_cyc),
        .i_to_lim   ({CNT_W{1'b0}}),
        .o_done     (w_off_done),
        .o_timeout  (w_unused_off_to)
    );

    // State registers for both sequences
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_on_state  <= ST_IDLE;
            r_off_state <= OFF_IDLE;
        end else begin
            r_on_state  <= w_on_nxt;
            r_off_state <= w_off_nxt;
        end
    end

    // Next-state logic: interlock beats abort beats normal progress
    always_comb begin
        w_on_nxt        = r_on_state;
        w_fail_code_nxt = FC_NONE;
        case (r_on_state)
            ST_IDLE: begin
                // Simultaneous ON and OFF requests: OFF wins
                if (i_on_req && !i_off_req) w_on_nxt = ST_CLR;
            end
            ST_CLR, ST_STEP_CHK, ST_STEP_DONE, ST_SYSTEM_ON: begin
                if (i_intl) begin
                    w_on_nxt        = ST_FAIL;
                    w_fail_code_nxt = FC_INTL;
                end else if (i_off_req && (r_on_state != ST_SYSTEM_ON)) begin
                    w_on_nxt        = ST_FAIL;
                    w_fail_code_nxt = FC_ABORT;
                end else begin
                    case (r_on_state)
                        ST_CLR: w_on_nxt = ST_STEP_CHK;
                        ST_STEP_CHK: begin
                            // A passing condition wins over a same-cycle timeout
                            if (w_st_done && r_cond) begin
                                w_on_nxt = ST_STEP_DONE;
                            end else if (w_st_to) begin
                                w_on_nxt        = ST_FAIL;
                                w_fail_code_nxt = FC_TIMEOUT;
                            end
                        end
                        ST_STEP_DONE: begin
                            if (r_step_idx == LAST_IDX) w_on_nxt = ST_SYSTEM_ON;
                            else                        w_on_nxt = ST_STEP_CHK;
                        end
                        default: begin
                            if (r_off_state == OFF_DONE) w_on_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_FAIL: begin
`ifdef MPS_SEQ_FAIL_LATCH_EN
                if (i_fail_clr) w_on_nxt = ST_IDLE;
`else
                w_on_nxt = ST_IDLE;
`endif
            end
            default: w_on_nxt = ST_IDLE;
        endcase

        w_off_nxt = r_off_state;
        case (r_off_state)
            OFF_IDLE:     if (i_off_req) w_off_nxt = OFF_MAIN_OFF;
            OFF_MAIN_OFF: if (w_off_done) w_off_nxt = OFF_DISCHA;
            OFF_DISCHA:   if (i_dc_v < i_dc_off_th) w_off_nxt = OFF_DONE;
            default:      w_off_nxt = OFF_IDLE;
        endcase
    end

    // Output and control decode from the current states
    always_comb begin
        o_on_state  = r_on_state;
        o_off_state = r_off_state;
        o_step_idx  = r_step_idx;
        o_fail_step = r_fail_step;
        o_fail_code = r_fail_code;
        o_system_on = (r_on_state == ST_SYSTEM_ON);
        o_busy      = ((r_on_state != ST_IDLE) && (r_on_state != ST_SYSTEM_ON))
                      || (r_off_state != OFF_IDLE);
        w_st_en     = (r_on_state == ST_STEP_CHK);
        w_st_clr    = (r_on_state != ST_STEP_CHK);
        w_off_en    = (r_off_state == OFF_MAIN_OFF);
        w_clr_entry = (r_on_state == ST_IDLE) && (w_on_nxt == ST_CLR);
        w_fail_set  = (r_on_state != ST_FAIL) && (w_on_nxt == ST_FAIL);
    end

    // Step index for the next cycle; the condition register tracks this
    // index so the first STEP_CHK cycle already sees its own step's result
    always_comb begin
        w_step_idx_nxt = r_step_idx;
        if (w_clr_entry) begin
            w_step_idx_nxt = 4'd0;
        end else if ((r_on_state == ST_STEP_DONE) && (w_on_nxt == ST_STEP_CHK)) begin
            w_step_idx_nxt = r_step_idx + 4'd1;
        end
        w_cond_sel = '0;
        w_cond_pol = 1'b0;
        w_cond_dc  = 1'b0;
        for (int k = 0; k < NUM_STEPS; k++) begin
            if (w_step_idx_nxt == 4'(k)) begin
                w_cond_sel = i_step_sel[k*SEL_W +: SEL_W];
                w_cond_pol = i_step_pol[k];
                w_cond_dc  = i_step_is_dc[k];
            end
        end
        w_cond_nxt = w_cond_dc ? (i_dc_v > i_dc_on_th)
                               : (i_ext_di[w_cond_sel] == w_cond_pol);
    end

    // Step index, registered step condition and fail record
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_step_idx  <= 4'd0;
            r_cond      <= 1'b0;
            r_fail_step <= 4'd0;
            r_fail_code <= FC_NONE;
        end else begin
            r_step_idx <= w_step_idx_nxt;
            r_cond     <= w_cond_nxt;
            if (w_clr_entry) begin
                r_fail_step <= 4'd0;
                r_fail_code <= FC_NONE;
            end else if (w_fail_set) begin
                r_fail_step <= r_step_idx;
                r_fail_code <= w_fail_code_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mps_seq_fsm.sv
// tb_mps_seq_fsm: bench for mps_seq_fsm with three steps. Expected timing
// and outcomes come from step rules evaluated with plain arithmetic.
module tb_mps_seq_fsm;

    localparam int N      = 3;
    localparam int DI_W   = 16;
    localparam int DCV_W  = 24;
    localparam int CNT_W  = 29;
    localparam int SEL_W  = 4;
    localparam int BUDGET = 2000;

    logic                   i_clk;
    logic                   i_rst;
    logic                   i_on_req;
    logic                   i_off_req;
    logic                   i_intl;
    logic [DI_W-1:0]        i_ext_di;
    logic [DCV_W-1:0]       i_dc_v;
    logic [DCV_W-1:0]       i_dc_on_th;
    logic [DCV_W-1:0]       i_dc_off_th;
    logic [N*SEL_W-1:0]     i_step_sel;
    logic [N-1:0]           i_step_pol;
    logic [N-1:0]           i_step_is_dc;
    logic [CNT_W-1:0]       i_hold_cyc;
    logic [CNT_W-1:0]       i_timeout_cyc;
    logic [CNT_W-1:0]       i_off_hold_cyc;
    logic                   i_fail_clr;
    logic [2:0]             o_on_state;
    logic [1:0]             o_off_state;
    logic [3:0]             o_step_idx;
    logic [3:0]             o_fail_step;
    logic [1:0]             o_fail_code;
    logic                   o_system_on;
    logic                   o_busy;

    int n_checks;
    int n_errors;
    logic [3:0] step_q[$];
    logic [3:0] exp_q[$];

    mps_seq_fsm #(.NUM_STEPS(N), .DI_W(DI_W), .DCV_W(DCV_W), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_on_req(i_on_req), .i_off_req(i_off_req),
        .i_intl(i_intl), .i_ext_di(i_ext_di), .i_dc_v(i_dc_v), .i_dc_on_th(i_dc_on_th),
        .i_dc_off_th(i_dc_off_th), .i_step_sel(i_step_sel), .i_step_pol(i_step_pol),
        .i_step_is_dc(i_step_is_dc), .i_hold_cyc(i_hold_cyc), .i_timeout_cyc(i_timeout_cyc),
        .i_off_hold_cyc(i_off_hold_cyc), .i_fail_clr(i_fail_clr), .o_on_state(o_on_state),
        .o_off_state(o_off_state), .o_step_idx(o_step_idx), .o_fail_step(o_fail_step),
        .o_fail_code(o_fail_code), .o_system_on(o_system_on), .o_busy(o_busy)
    );

    // Clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Watchdog
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Reference: cycles from the ON request edge until SYSTEM_ON or FAIL.
    // One CLR cycle, then per passing step hold+1 check cycles plus one done
    // cycle; a failing step checks for hold+timeout+1 cycles then fails.
    function automatic void predict(output int cyc, output logic [2:0] st,
                                    output logic [3:0] fstep);
        int h;
        int t;
        logic ok;
        h = int'(i_hold_cyc);
        t = int'(i_timeout_cyc);
        cyc = 1;
        st = 3'd4;
        fstep = 4'd0;
        for (int k = 0; k < N; k++) begin
            if (i_step_is_dc[k]) ok = (i_dc_v > i_dc_on_th);
            else                 ok = (i_ext_di[i_step_sel[k*SEL_W +: SEL_W]] == i_step_pol[k]);
            if (!ok) begin
                cyc += h + t + 2;
                st = 3'd5;
                fstep = 4'(k);
                return;
            end
            cyc += h + 2;
        end
        cyc += 1;
    endfunction

    task automatic set_plan_cfg();
        i_step_sel    = {4'd2, 4'd0, 4'd0};
        i_step_pol    = 3'b001;
        i_step_is_dc  = 3'b010;
        i_ext_di      = 16'h0001;
        i_dc_v        = 24'd300;
        i_dc_on_th    = 24'd280;
        i_dc_off_th   = 24'd10;
        i_hold_cyc    = 29'd10;
        i_timeout_cyc = 29'd50;
        i_off_hold_cyc = 29'd20;
    endtask

    // Pulse ON and run until SYSTEM_ON or FAIL; logs the step index trail
    task automatic run_on(output int cyc, output logic [2:0] st);
        cyc = -1;
        st = 3'd0;
        step_q.delete();
        i_on_req = 1'b1;
        for (int n = 1; n <= BUDGET; n++) begin
            @(negedge i_clk);
            i_on_req = 1'b0;
            if (step_q.size() == 0 || step_q[$] != o_step_idx) step_q.push_back(o_step_idx);
            if (o_on_state == 3'd4 || o_on_state == 3'd5) begin
                cyc = n;
                st = o_on_state;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (o_on_state == 3'd0 && o_off_state == 2'd0) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s idle: on=%0d off=%0d, required 0/0", name, o_on_state, o_off_state);
        end
    endtask

    // Leave FAIL and check the fail code persists into IDLE
    task automatic leave_fail(input logic [1:0] code);
`ifdef MPS_SEQ_FAIL_LATCH_EN
        i_on_req = 1'b1;
        repeat (3) @(negedge i_clk);
        i_on_req = 1'b0;
        n_checks++;
        if (o_on_state !== 3'd5) begin
            n_errors++;
            $display("FAIL fail_latched: on=%0d required 5", o_on_state);
        end
        i_fail_clr = 1'b1;
        @(negedge i_clk);
        i_fail_clr = 1'b0;
`else
        @(negedge i_clk);
`endif
        n_checks++;
        if (o_on_state !== 3'd0 || o_fail_code !== code) begin
            n_errors++;
            $display("FAIL fail_exit: on=%0d code=%0d, required on=0 code=%0d",
                     o_on_state, o_fail_code, code);
        end
    endtask

    task automatic check_outcome(input string name);
        int cyc;
        int ecyc;
        logic [2:0] st;
        logic [2:0] est;
        logic [3:0] efs;
        predict(ecyc, est, efs);
        run_on(cyc, st);
        n_checks++;
        if (cyc != ecyc || st !== est) begin
            n_errors++;
            $display("FAIL %s timing: state %0d at cycle %0d, required state %0d at cycle %0d",
                     name, st, cyc, est, ecyc);
        end
        exp_q.delete();
        for (int k = 0; k <= ((est == 3'd4) ? N - 1 : int'(efs)); k++) exp_q.push_back(4'(k));
        n_checks++;
        if (step_q != exp_q) begin
            n_errors++;
            $display("FAIL %s step_trail: got %p required %p", name, step_q, exp_q);
        end
        n_checks++;
        if (est == 3'd5) begin
            if (o_fail_code !== 2'd2 || o_fail_step !== efs) begin
                n_errors++;
                $display("FAIL %s fail_rec: code=%0d step=%0d, required code=2 step=%0d",
                         name, o_fail_code, o_fail_step, efs);
            end
        end else if (o_fail_code !== 2'd0 || o_busy !== 1'b0 || o_system_on !== 1'b1) begin
            n_errors++;
            $display("FAIL %s on_flags: code=%0d busy=%0d sys=%0d, required 0/0/1",
                     name, o_fail_code, o_busy, o_system_on);
        end
    endtask

    task automatic go_off();
        i_dc_v = '0;
        i_off_hold_cyc = 29'd2;
        i_off_req = 1'b1;
        @(negedge i_clk);
        i_off_req = 1'b0;
        wait_idle("go_off");
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_on_state, o_off_state, o_step_idx, o_fail_step, o_fail_code, o_system_on, o_busy} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: on=%0d off=%0d idx=%0d fs=%0d fc=%0d sys=%0d busy=%0d, required all 0",
                     o_on_state, o_off_state, o_step_idx, o_fail_step, o_fail_code, o_system_on, o_busy);
        end
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        n_checks++;
        if (o_on_state !== 3'd0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: on=%0d busy=%0d, required 0/0", o_on_state, o_busy);
        end
    endtask

    task automatic test_on_pass();
        set_plan_cfg();
        check_outcome("on_pass");
    endtask

    task automatic test_off_seq();
        int n_main;
        logic flags_ok;
        i_off_req = 1'b1;
        @(negedge i_clk);
        i_off_req = 1'b0;
        n_main = 0;
        flags_ok = 1'b1;
        for (int n = 0; n < BUDGET && o_off_state == 2'd1; n++) begin
            n_main++;
            if (o_system_on !== 1'b1 || o_busy !== 1'b1) flags_ok = 1'b0;
            @(negedge i_clk);
        end
        n_checks++;
        if (n_main != int'(i_off_hold_cyc) + 1 || !flags_ok) begin
            n_errors++;
            $display("FAIL off_main: %0d cycles flags_ok=%0d, required %0d cycles flags_ok=1",
                     n_main, flags_ok, int'(i_off_hold_cyc) + 1);
        end
        repeat (5) @(negedge i_clk);
        n_checks++;
        if (o_off_state !== 2'd2 || o_on_state !== 3'd4) begin
            n_errors++;
            $display("FAIL off_discha: off=%0d on=%0d, required 2/4", o_off_state, o_on_state);
        end
        i_dc_v = 24'd5;
        @(negedge i_clk);
        n_checks++;
        if (o_off_state !== 2'd3 || o_on_state !== 3'd4) begin
            n_errors++;
            $display("FAIL off_done: off=%0d on=%0d, required 3/4", o_off_state, o_on_state);
        end
        @(negedge i_clk);
        n_checks++;
        if (o_off_state !== 2'd0 || o_on_state !== 3'd0 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL off_to_idle: off=%0d on=%0d busy=%0d, required 0/0/0",
                     o_off_state, o_on_state, o_busy);
        end
    endtask

    task automatic test_dc_timeout();
        set_plan_cfg();
        i_dc_v = 24'd100;
        check_outcome("dc_timeout");
        leave_fail(2'd2);
    endtask

    task automatic test_intl();
        logic found;
        set_plan_cfg();
        i_on_req = 1'b1;
        @(negedge i_clk);
        i_on_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (o_on_state == 3'd2 && o_step_idx == 4'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL intl_reach_step2: idx=%0d on=%0d, required 2/2", o_step_idx, o_on_state);
        end
        i_intl = 1'b1;
        @(negedge i_clk);
        i_intl = 1'b0;
        n_checks++;
        if (o_on_state !== 3'd5 || o_fail_code !== 2'd1 || o_fail_step !== 4'd2) begin
            n_errors++;
            $display("FAIL intl_fail: on=%0d code=%0d step=%0d, required 5/1/2",
                     o_on_state, o_fail_code, o_fail_step);
        end
        leave_fail(2'd1);
    endtask

    task automatic test_abort();
        set_plan_cfg();
        i_on_req = 1'b1;
        @(negedge i_clk);
        i_on_req = 1'b0;
        repeat (4) @(negedge i_clk);
        i_off_req = 1'b1;
        @(negedge i_clk);
        i_off_req = 1'b0;
        n_checks++;
        if (o_on_state !== 3'd5 || o_fail_code !== 2'd3 || o_fail_step !== 4'd0 || o_off_state !== 2'd1) begin
            n_errors++;
            $display("FAIL abort_fail: on=%0d code=%0d step=%0d off=%0d, required 5/3/0/1",
                     o_on_state, o_fail_code, o_fail_step, o_off_state);
        end
        leave_fail(2'd3);
        n_checks++;
        if (o_off_state !== 2'd1) begin
            n_errors++;
            $display("FAIL abort_off_runs: off=%0d required 1", o_off_state);
        end
        i_dc_v = 24'd5;
        wait_idle("abort");
    endtask

    task automatic test_simultaneous();
        i_on_req = 1'b1;
        i_off_req = 1'b1;
        @(negedge i_clk);
        i_on_req = 1'b0;
        i_off_req = 1'b0;
        n_checks++;
        if (o_on_state !== 3'd0 || o_off_state !== 2'd1) begin
            n_errors++;
            $display("FAIL simul_off_wins: on=%0d off=%0d, required 0/1", o_on_state, o_off_state);
        end
        wait_idle("simul");
    endtask

    task automatic test_reset_mid();
        logic found;
        set_plan_cfg();
        i_on_req = 1'b1;
        @(negedge i_clk);
        i_on_req = 1'b0;
        found = 1'b0;
        for (int n = 0; n < BUDGET; n++) begin
            if (o_on_state == 3'd2 && o_step_idx == 4'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        i_rst = 1'b0;
        #1;
        n_checks++;
        if (!found || {o_on_state, o_off_state, o_step_idx, o_fail_step, o_fail_code, o_system_on, o_busy} !== 17'd0) begin
            n_errors++;
            $display("FAIL reset_mid: found=%0d on=%0d idx=%0d busy=%0d, required found=1 all outputs 0",
                     found, o_on_state, o_step_idx, o_busy);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        n_checks++;
        if (o_on_state !== 3'd0 || o_fail_code !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_mid_release: on=%0d code=%0d, required 0/0", o_on_state, o_fail_code);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < N; k++) i_step_sel[k*SEL_W +: SEL_W] = 4'($urandom_range(15, 0));
            i_step_pol    = 3'($urandom_range(7, 0));
            i_step_is_dc  = 3'($urandom_range(7, 0));
            i_ext_di      = 16'($urandom_range(16'hffff, 0));
            i_dc_v        = 24'($urandom_range(500, 0));
            i_dc_on_th    = 24'($urandom_range(500, 0));
            i_hold_cyc    = 29'($urandom_range(6, 0));
            i_timeout_cyc = 29'($urandom_range(6, 0));
            if (t == 0) begin
                // Zero hold and zero timeout with every step satisfied
                i_step_is_dc  = 3'b111;
                i_dc_v        = 24'd400;
                i_dc_on_th    = 24'd399;
                i_hold_cyc    = '0;
                i_timeout_cyc = '0;
            end
            check_outcome("random");
            if (o_on_state == 3'd4) go_off();
            else if (o_on_state == 3'd5) leave_fail(2'd2);
            wait_idle("random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        i_rst = 1'b0;
        i_on_req = 1'b0;
        i_off_req = 1'b0;
        i_intl = 1'b0;
        i_fail_clr = 1'b0;
        set_plan_cfg();
        test_reset();
        test_on_pass();
        test_off_seq();
        test_dc_timeout();
        test_intl();
        test_abort();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mps_seq_fsm.md
Name: mps_seq_fsm

Overview:
- Parametrised successor of the BR MPS operation sequencer.
- ON sequence is a runtime-configurable list of NUM_STEPS check steps. Each step is either a DI-level check or a DC-link voltage check, with a programmable hold time and timeout.
- OFF sequence is main-off hold, then discharge to below threshold, then SYSTEM_OFF.
- Adds integer DC thresholds (no float IP), per-step fail reporting, fail codes and ON abort on OFF request. Sits between the MPS register bank and the external DI/DC-ADC path.

Parameters:
- NUM_STEPS, 6: number of ON check steps, 1..16.
- DI_W, 16: external DI width.
- DCV_W, 24: unsigned DC-link voltage code width.
- CNT_W, 29: hold/timeout counter width.
- SEL_W, $clog2(DI_W): DI index select width per step.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_on_req  in  1  ON request pulse
- i_off_req  in  1  OFF request pulse
- i_intl  in  1  interlock, level
- i_ext_di  in  DI_W  external digital inputs
- i_dc_v  in  DCV_W  DC-link voltage code
- i_dc_on_th  in  DCV_W  DC step passes when i_dc_v > i_dc_on_th
- i_dc_off_th  in  DCV_W  discharge done when i_dc_v < i_dc_off_th
- i_step_sel  in  NUM_STEPS*SEL_W  DI index per step; step k at [k*SEL_W +: SEL_W]
- i_step_pol  in  NUM_STEPS  expected DI level per step
- i_step_is_dc  in  NUM_STEPS  1 = DC check step; sel/pol ignored
- i_hold_cyc  in  CNT_W  ON hold cycles per step
- i_timeout_cyc  in  CNT_W  cycles after hold before timeout
- i_off_hold_cyc  in  CNT_W  main-off hold cycles
- i_fail_clr  in  1  clears latched fail (feature only)
- o_on_state  out  3  ON FSM state
- o_off_state  out  2  OFF FSM state
- o_step_idx  out  4  current or last step index
- o_fail_step  out  4  step index at failure
- o_fail_code  out  2  0 none, 1 interlock, 2 timeout, 3 abort
- o_system_on  out  1  high in SYSTEM_ON
- o_busy  out  1  ON state not IDLE/SYSTEM_ON, or OFF state not IDLE

Behaviour:
- Reset i_rst, asynchronous, active-low; clock i_clk. All outputs, counters and states reset to 0.
- ON FSM states:
  - IDLE = 0: on i_on_req go to CLR. i_on_req is ignored unless in IDLE.
  - CLR = 1: step_idx, counters, fail_step and fail_code cleared; next state STEP_CHK.
  - STEP_CHK = 2:
    - hold_cnt increments, saturating at i_hold_cyc.
    - Once saturated: step condition true goes to STEP_DONE; otherwise timeout_cnt increments.
    - timeout_cnt == i_timeout_cyc goes to FAIL with code 2.
  - STEP_DONE = 3:
    - Counters cleared.
    - step_idx == NUM_STEPS-1 goes to SYSTEM_ON; else step_idx+1 and back to STEP_CHK.
  - SYSTEM_ON = 4: leaves to IDLE on the cycle OFF state == OFF_DONE.
  - FAIL = 5: o_fail_step <= step_idx; one cycle, then IDLE.
- Step condition (registered, one cycle of latency, reset 0):
  - DI step: i_ext_di[sel] == pol.
  - DC step: i_dc_v > i_dc_on_th, unsigned.
- i_hold_cyc == 0 means the condition is checked on the first STEP_CHK cycle.
- Priority in every non-IDLE, non-FAIL ON state:
  1. i_intl: FAIL, code 1.
  2. i_off_req during CLR..STEP_DONE: FAIL, code 3.
  3. Normal transitions.
- OFF FSM states:
  - OFF_IDLE = 0: i_off_req goes to MAIN_OFF.
  - MAIN_OFF = 1: off_cnt counts to i_off_hold_cyc, then DISCHA.
  - DISCHA = 2: goes to OFF_DONE when i_dc_v < i_dc_off_th.
  - OFF_DONE = 3: one cycle, then OFF_IDLE.
  - i_off_req while OFF FSM is busy is ignored. Interlock does not stop the OFF sequence.
- Simultaneous i_on_req and i_off_req in IDLE: OFF wins, ON stays IDLE.
- Counters are CNT_W wide, saturate, and never wrap.
- Reset mid-sequence returns both FSMs to idle with no fail record.

Optional Feature:
- MPS_SEQ_FAIL_LATCH_EN defined: FAIL holds until i_fail_clr, then goes to IDLE. i_on_req is ignored while in FAIL.
- Not defined: FAIL lasts one cycle and i_fail_clr is unused.
- In both cases o_fail_code and o_fail_step persist until the next CLR.

Decomposition:
- Package mps_seq_pkg holds:
  - ON state localparams: ST_IDLE..ST_FAIL.
  - OFF state localparams: OFF_IDLE..OFF_DONE.
  - Fail codes: FC_NONE, FC_INTL, FC_TIMEOUT, FC_ABORT.
- Sub-module mps_hold_timer provides a saturating hold counter plus timeout counter with clr/en/done/timeout outputs. It is used for step timing; a second instance with timeout disabled is used for MAIN_OFF.

Test Plan:
- NUM_STEPS=3, hold=10, steps DI0=1, DC, DI2=0; DI and DC valid → SYSTEM_ON; o_step_idx sequences 0,1,2.
- Step 1 DC with i_dc_v=100, th=280, timeout=50 → FAIL after 10+50 (+latency) cycles; fail_code=2, fail_step=1.
- i_intl pulse at step 2 → FAIL next cycle; fail_code=1, fail_step=2; then IDLE (feature off).
- SYSTEM_ON, i_off_req, off_hold=20, dc drops 300→5 with off_th=10 → MAIN_OFF for 20 cycles, DISCHA, OFF_DONE; ON FSM goes to IDLE.
- i_off_req during step 0 → FAIL with fail_code=3 while the OFF sequence runs; with MPS_SEQ_FAIL_LATCH_EN, FAIL holds until i_fail_clr.
- Reset asserted in STEP_CHK → all outputs 0 immediately.
